// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and types for the SRAM device model
// Purpose: board-part geometry, latency limit and the read-pipe entry layout.
package sram_pkg;

  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DQ_W       = 16;
  localparam int SRAM_MAX_RD_LAT = 4;
  // Upper and lower byte lanes (UB_N / LB_N).
  localparam int SRAM_LANES      = 2;

  typedef struct packed {
    logic                  valid;
    logic [SRAM_DQ_W-1:0]  data;
    logic [SRAM_LANES-1:0] lane_en;
  } sram_rd_entry_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - DEPTH-deep valid/data shift register for read returns
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears valids only)
//   i_valid/i_data entry captured at every posedge
//   o_valid/o_data output stage; combinational bypass when DEPTH == 0
module sram_rd_pipe #(
  parameter int DEPTH = 0,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;
    assign o_valid = i_valid;
    assign o_data  = i_data;
  end else begin : g_shift
    logic [DEPTH-1:0] r_valid;
    logic [W-1:0]     r_data [DEPTH];

    // Shifts every cycle; a false i_valid inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= i_valid;
        for (int i = 1; i < DEPTH; i++) begin
          r_valid[i] <= r_valid[i-1];
        end
      end
    end

    // Data needs no reset: it is only ever used under its valid bit.
    always_ff @(posedge clk) begin
      r_data[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
      end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
  end

endmodule

// File: rtl/sram_device_model.sv
// rtl/sram_device_model.sv - clocked responder model of the external 16-bit SRAM
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   SRAM_ADDR                 word address (only ADDR_W LSBs decoded, upper bits alias)
//   SRAM_DQ                   bidirectional data bus
//   SRAM_WE_N/CE_N/OE_N       active-low write, chip and output enables
//   rd_cnt, wr_cnt            saturating accepted-read / committed-write counters
//   collision_err             sticky: write while a read result was at the output stage
// Build option SRAM_MODEL_BYTE_MASK_EN adds SRAM_UB_N/SRAM_LB_N byte-lane enables.
module sram_device_model
  import sram_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = SRAM_DQ_W,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0]      SRAM_DQ,
  input  logic                   SRAM_WE_N,
  input  logic                   SRAM_CE_N,
  input  logic                   SRAM_OE_N,
`ifdef SRAM_MODEL_BYTE_MASK_EN
  input  logic                   SRAM_UB_N,
  input  logic                   SRAM_LB_N,
`endif
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic                   collision_err
);

  localparam int LANE_W     = DATA_W / SRAM_LANES;
  localparam int PIPE_DEPTH = (RD_LAT > SRAM_MAX_RD_LAT) ? SRAM_MAX_RD_LAT : RD_LAT;
  localparam int ENTRY_W    = SRAM_LANES + DATA_W;

  logic [DATA_W-1:0]     r_mem [2**ADDR_W];
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic                  r_collision;

  logic [ADDR_W-1:0]     w_addr;
  logic                  w_rd_cond;
  logic                  w_wr_cond;
  logic [SRAM_LANES-1:0] w_lane_en;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_out_valid;
  logic [SRAM_LANES-1:0] w_out_lane;
  logic [DATA_W-1:0]     w_out_data;
  logic                  w_drive;
  logic [SRAM_LANES-1:0] w_lane_oe;
  logic                  w_dq_oe;

  assign w_addr = SRAM_ADDR[ADDR_W-1:0];
  if (ADDR_W < SRAM_ADDR_W) begin : g_addr_alias
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^SRAM_ADDR[SRAM_ADDR_W-1:ADDR_W];
  end

`ifdef SRAM_MODEL_BYTE_MASK_EN
  assign w_lane_en = {~SRAM_UB_N, ~SRAM_LB_N};
`else
  assign w_lane_en = '1;
`endif

  // Nothing is accepted while reset is held.
  assign w_rd_cond = !rst && !SRAM_CE_N &&  SRAM_WE_N;
  assign w_wr_cond = !rst && !SRAM_CE_N && !SRAM_WE_N;
  assign w_rd_data = r_mem[w_addr];

  // Array is deliberately never reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_cond) begin
      for (int l = 0; l < SRAM_LANES; l++) begin
        if (w_lane_en[l]) begin
          r_mem[w_addr][l*LANE_W +: LANE_W] <= SRAM_DQ[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  sram_rd_pipe #(
    .DEPTH (PIPE_DEPTH),
    .W     (ENTRY_W)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd_cond),
    .i_data  ({w_lane_en, w_rd_data}),
    .o_valid (w_out_valid),
    .o_data  ({w_out_lane, w_out_data})
  );

  // Gating on rst takes the bus to hi-Z the moment reset asserts, even with RD_LAT=0.
  assign w_drive   = w_out_valid && !SRAM_OE_N && SRAM_WE_N && !rst;
  assign w_lane_oe = {SRAM_LANES{w_drive}} & w_out_lane;
  assign w_dq_oe   = |w_lane_oe;

`ifdef SRAM_MODEL_BYTE_MASK_EN
  for (genvar l = 0; l < SRAM_LANES; l++) begin : g_lane_drv
    assign SRAM_DQ[l*LANE_W +: LANE_W] = w_lane_oe[l] ? w_out_data[l*LANE_W +: LANE_W]
                                                      : {LANE_W{1'bz}};
  end
`else
  assign SRAM_DQ = w_dq_oe ? w_out_data : {DATA_W{1'bz}};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_collision <= 1'b0;
    end else begin
      if (w_rd_cond && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_wr_cond && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      // With RD_LAT=0 the output valid is the read condition itself, so this never fires.
      if (w_wr_cond && w_out_valid) begin
        r_collision <= 1'b1;
      end
    end
  end

  assign rd_cnt        = r_rd_cnt;
  assign wr_cnt        = r_wr_cnt;
  assign collision_err = r_collision;

endmodule

// File: tb/tb_sram_device_model.sv
// tb/tb_sram_device_model.sv - scoreboard bench for sram_device_model at RD_LAT 0..3
module tb_sram_device_model;

  localparam int NL = 4;
  localparam int CMAX = 63;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] addr = '0;
  logic        we_n = 1'b1;
  logic        ce_n = 1'b1;
  logic        oe_n = 1'b1;
  logic        ub_n = 1'b0;
  logic        lb_n = 1'b0;
  logic [15:0] wdata = '0;

  logic [5:0]  rd_cnt_o [NL];
  logic [5:0]  wr_cnt_o [NL];
  logic        coll_o   [NL];

  int cycle  = 8;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [15:0] mask;
  } exp_t;

  exp_t q_exp [NL][$];

  logic [15:0] m_mem [1024];
  int          m_rd = 0;
  int          m_wr = 0;
  bit          m_coll [NL];
  bit          h_rd   [8];
  bit          h_rst  [8];
  logic [15:0] h_data [8];
  logic [15:0] h_mask [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : gen_lat
    wire [15:0] dq;
    assign dq = (!we_n) ? wdata : 16'hzzzz;

    sram_device_model #(
      .ADDR_W (10),
      .DATA_W (16),
      .RD_LAT (g),
      .CNT_W  (6)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .SRAM_ADDR     (addr),
      .SRAM_DQ       (dq),
      .SRAM_WE_N     (we_n),
      .SRAM_CE_N     (ce_n),
      .SRAM_OE_N     (oe_n),
`ifdef SRAM_MODEL_BYTE_MASK_EN
      .SRAM_UB_N     (ub_n),
      .SRAM_LB_N     (lb_n),
`endif
      .rd_cnt        (rd_cnt_o[g]),
      .wr_cnt        (wr_cnt_o[g]),
      .collision_err (coll_o[g])
    );

    // Monitor: every cycle the bus must be driven exactly when an expectation is due.
    always @(negedge clk) begin
      bit   exp_drv;
      bit   act_drv;
      exp_t e;
      act_drv = u_dut.w_dq_oe;
      exp_drv = (q_exp[g].size() > 0) && (q_exp[g][0].cyc == cycle);
      n_cmp++;
      if (act_drv != exp_drv) begin
        n_fail++;
        $display("FAIL dq_drive lat%0d cycle %0d: driven=%0d expected=%0d", g, cycle, act_drv, exp_drv);
      end
      if (exp_drv) begin
        e = q_exp[g].pop_front();
        if (act_drv) begin
          n_cmp++;
          if ((dq & e.mask) !== (e.data & e.mask)) begin
            n_fail++;
            $display("FAIL dq_data lat%0d cycle %0d: got %h expected %h", g, cycle, dq & e.mask, e.data & e.mask);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lane_mask();
    return {{8{~ub_n}}, {8{~lb_n}}};
  endfunction

  // One bus cycle: called just after a posedge, returns just after the next one.
  task automatic step(input bit r, input bit c_n, input bit w_n, input bit o_n,
                      input logic [17:0] a, input logic [15:0] wd);
    bit          rd;
    bit          wr;
    bit          due;
    bit          coll_set [NL];
    int          s;
    int          p;
    logic [15:0] lm;
    exp_t        e;
    rst = r; ce_n = c_n; we_n = w_n; oe_n = o_n; addr = a; wdata = wd;
    cycle++;
    lm = lane_mask();
    if (r) begin
      m_rd = 0;
      m_wr = 0;
      for (int l = 0; l < NL; l++) m_coll[l] = 1'b0;
    end
    rd = !r && !c_n &&  w_n;
    wr = !r && !c_n && !w_n;
    s = cycle % 8;
    h_rd[s]   = rd;
    h_rst[s]  = r;
    h_data[s] = m_mem[a[9:0]];
    h_mask[s] = lm;
    // A read captured L cycles ago is due now unless a reset cycle intervened.
    for (int l = 0; l < NL; l++) begin
      p = (cycle - l) % 8;
      due = h_rd[p];
      for (int k = 0; k <= l; k++) if (h_rst[(cycle - k) % 8]) due = 1'b0;
      if (due && !o_n && w_n) begin
        e.cyc = cycle; e.data = h_data[p]; e.mask = h_mask[p];
        q_exp[l].push_back(e);
      end
      coll_set[l] = due && wr;
    end
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("rd_cnt lat%0d cyc%0d", l, cycle), int'(rd_cnt_o[l]), m_rd);
      check($sformatf("wr_cnt lat%0d cyc%0d", l, cycle), int'(wr_cnt_o[l]), m_wr);
      check($sformatf("collision lat%0d cyc%0d", l, cycle), int'(coll_o[l]), int'(m_coll[l]));
    end
    @(posedge clk);
    if (rd && m_rd < CMAX) m_rd++;
    if (wr) begin
      if (m_wr < CMAX) m_wr++;
      m_mem[a[9:0]] = (m_mem[a[9:0]] & ~lm) | (wd & lm);
    end
    for (int l = 0; l < NL; l++) if (coll_set[l]) m_coll[l] = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
  endtask

  initial begin
    bit          r;
    bit          c;
    bit          w;
    bit          o;
    logic [17:0] a;
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      h_rd[i] = 1'b0; h_rst[i] = 1'b0; h_data[i] = '0; h_mask[i] = '0;
    end
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);

    // Write then immediate read of the same word.
    step(1'b0, 1'b0, 1'b0, 1'b1, 18'h00010, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 1'b0, 18'h00010, 16'h0);
    idle(4);
    check("first_rd_cnt", int'(rd_cnt_o[0]), 1);
    check("first_wr_cnt", int'(wr_cnt_o[0]), 1);

    // Give every word a known value.
    for (int i = 0; i < 1024; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 18'(i), 16'($urandom));

    // Four-word burst.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 18'h100 + 18'(i), 16'hA0 + 16'(i));
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 18'h100 + 18'(i), 16'h0);
    idle(4);

    // Upper address bits alias.
    step(1'b0, 1'b0, 1'b0, 1'b1, 18'h00405, 16'hBEEF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 18'h00005, 16'h0);
    idle(4);

    // Write on the edge after a read: collides for RD_LAT=1, still commits.
    step(1'b0, 1'b0, 1'b1, 1'b0, 18'h00020, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 18'h00020, 16'h5A5A);
    idle(4);
    check("collision_lat1_set", int'(coll_o[1]), 1);
    check("collision_lat0_never", int'(coll_o[0]), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 18'h00020, 16'h0);
    idle(4);
    step(1'b1, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
    idle(1);
    check("collision_lat1_cleared", int'(coll_o[1]), 0);

    // Reset in the middle of a burst, then read the same words back.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 18'h200 + 18'(i), 16'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
    idle(5);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 18'h200 + 18'(i), 16'h0);
    idle(4);

`ifdef SRAM_MODEL_BYTE_MASK_EN
    step(1'b0, 1'b0, 1'b0, 1'b1, 18'h7, 16'hFFFF);
    ub_n = 1'b0; lb_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 18'h7, 16'h1200);
    ub_n = 1'b0; lb_n = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 18'h7, 16'h0);
    idle(4);
    check("byte_mask_model_word", int'(m_mem[7]), 16'h12FF);
`endif

    // Randomized traffic, including occasional resets and aliased addresses.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 7) == 0);
      a = 18'($urandom);
      d = 16'($urandom);
      step(r, c, w, o, a, d);
    end
    idle(6);

    for (int l = 0; l < NL; l++) check($sformatf("leftover_expect lat%0d", l), q_exp[l].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
